dm_port_arbiter: RTL

Two-port arbiter and sequencer for the 8-bit, 256-entry data memory. It shares one memory port between the pipeline's stage-3 memory access and a debug/loader port. Core requests have priority. A starvation counter guarantees debug progress, and a lock mode lets the debug port freeze the core for multi-byte bursts. Core-side conflicts produce a same-cycle stall that the top level uses to hold the PC increment and pipeline registers.

---
 rtl/dm_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single 8-bit x 256 data-memory port between the
// pipeline stage-3 access (core) and the debug/loader port (dbg).
// Core has priority. A starvation counter forces a debug win after
// STARVE_LIMIT denied cycles. A lock mode lets debug freeze the core for bursts.
//   core_*     : core request, same-cycle read data and stall
//   dbg_*      : debug request, grant, registered read data/valid, lock request
//   locked     : registered, high while in LOCK
//   conflict_cnt : saturating count of cycles where both sides request
//   mem_*      : memory port (combinational read data)
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [7:0]  core_addr,
  input  logic [7:0]  core_wdata,
  output logic [7:0]  core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_addr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [7:0]  dbg_rdata,
  output logic        locked,
  output logic [15:0] conflict_cnt,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CONF_W = 16;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic [CNT_W-1:0]    w_starve_nxt;
  logic                w_dbg_win;
  logic                w_core_win;
  logic                w_dbg_gnt;
  logic                w_core_gnt;
  logic                w_dbg_rd;
  logic                r_dbg_rvalid;
  logic [7:0]          r_dbg_rdata;
  logic [CONF_W-1:0]   r_conflict_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grant decision and starvation counter update
  always_comb begin
    w_state_nxt  = r_state;
    w_dbg_win    = 1'b0;
    w_core_win   = 1'b0;
    w_starve_nxt = '0;
    case (r_state)
      S_ARB: begin
        w_dbg_win  = dbg_req & (~core_req | (r_starve_cnt == STARVE_MAX));
        w_core_win = core_req & ~w_dbg_win;
        if (dbg_req && !w_dbg_win) begin
          w_starve_nxt = (r_starve_cnt == STARVE_MAX) ? r_starve_cnt
                                                      : r_starve_cnt + CNT_W'(1);
        end
        if (w_dbg_win && dbg_lock) begin
          w_state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        // Core is frozen; the drop of dbg_lock is seen on this cycle's edge
        w_dbg_win = dbg_req;
        if (!dbg_lock) begin
          w_state_nxt = S_ARB;
        end
      end
    endcase
  end

  // Grants are suppressed while reset is asserted so no access reaches memory
  assign w_dbg_gnt  = w_dbg_win & rst_n;
  assign w_core_gnt = w_core_win & rst_n;
  assign w_dbg_rd   = w_dbg_win & ~dbg_we;

  // Memory port mux: granted side drives, otherwise idle on the core address
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (w_dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (w_core_gnt) begin
      mem_we    = core_we;
    end
  end

  // Starvation counter, debug read capture and conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt   <= '0;
      r_dbg_rvalid   <= 1'b0;
      r_dbg_rdata    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_dbg_rvalid <= w_dbg_rd;
      if (w_dbg_rd) begin
        r_dbg_rdata <= mem_rdata;
      end
      if (core_req && dbg_req && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CONF_W'(1);
      end
    end
  end

  assign core_rdata   = mem_rdata;
  assign core_stall   = core_req & ~w_core_gnt;
  assign dbg_gnt      = w_dbg_gnt;
  assign dbg_rvalid   = r_dbg_rvalid;
  assign dbg_rdata    = r_dbg_rdata;
  assign locked       = (r_state == S_LOCK);
  assign conflict_cnt = r_conflict_cnt;

endmodule
